// File: rtl/exe_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage; master drives the ID/EX fields,
// slave (exe_stage) returns results, gated controls, NZCV and the stall request.
interface exe_stage_if;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic        B_in;
  logic        S_in;
  logic [3:0]  EXE_CMD_in;
  logic [31:0] PC_in;
  logic [31:0] Val_Rn_in;
  logic [31:0] Val_Rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  Dest_in;

  logic [31:0] ALU_result;
  logic [31:0] Val_Rm_out;
  logic [3:0]  Dest_out;
  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic        MEM_W_EN_out;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  logic        stall_out;

  modport master (
    output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in, PC_in,
           Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in, signed_imm_24_in, Dest_in,
    input  ALU_result, Val_Rm_out, Dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
           branch_taken, branch_addr, status_out, stall_out
  );

  modport slave (
    input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in, PC_in,
           Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in, signed_imm_24_in, Dest_in,
    output ALU_result, Val_Rm_out, Dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
           branch_taken, branch_addr, status_out, stall_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, 0-cycle ALU, branch target and NZCV; MUL (macro EXE_MUL_EN)
// takes 32/MUL_STEP+2 cycles and holds stall_out high to freeze IF/ID/ID-EX, sending bubbles downstream.
module exe_stage #(
  parameter int MUL_STEP = 2
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                         CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                         CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000,
                         CMD_MUL = 4'b1010;

  if (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4 && MUL_STEP != 8) begin : g_bad_step
    $error("exe_stage: MUL_STEP must be 1, 2, 4 or 8");
  end

  logic [3:0]  status;  // {N,Z,C,V}
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [31:0] mul_res;
  logic [31:0] add_b;
  logic [32:0] sum;
  logic        cin;
  logic        n_f, z_f, c_f, v_f;
  logic        mem_op, is_mul;
  logic        stall_raw, stall, mul_kill;
  logic [31:0] imm32;
  logic [31:0] rm;
  logic [4:0]  shamt;
  logic [3:0]  rot;

  assign mem_op = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  assign is_mul = (bus.EXE_CMD_in == CMD_MUL);
  assign stall  = stall_raw & rst;

  assign imm32 = {24'b0, bus.shift_operand_in[7:0]};
  assign rm    = bus.Val_Rm_in;
  assign shamt = bus.shift_operand_in[11:7];
  assign rot   = bus.shift_operand_in[11:8];

  always_comb begin
    val2 = '0;
    if (mem_op) begin
      val2 = {20'b0, bus.shift_operand_in};
    end else if (bus.imm_in) begin
      val2 = (imm32 >> {rot, 1'b0}) | (imm32 << (6'd32 - {1'b0, rot, 1'b0}));
    end else begin
      unique case (bus.shift_operand_in[6:5])
        2'b00:   val2 = rm << shamt;
        2'b01:   val2 = rm >> shamt;
        2'b10:   val2 = $signed(rm) >>> shamt;
        default: val2 = (rm >> shamt) | (rm << (6'd32 - {1'b0, shamt}));
      endcase
    end
  end

  // Subtraction runs through the same adder as Rn + ~Val2 + cin, so carry-out is NOT borrow.
  always_comb begin
    add_b = val2;
    cin   = 1'b0;
    if (!mem_op) begin
      unique case (bus.EXE_CMD_in)
        CMD_ADC: cin = status[1];
        CMD_SUB: begin add_b = ~val2; cin = 1'b1;      end
        CMD_SBC: begin add_b = ~val2; cin = status[1]; end
        default: ;
      endcase
    end
    sum = {1'b0, bus.Val_Rn_in} + {1'b0, add_b} + {32'b0, cin};
  end

  always_comb begin
    alu_res = '0;
    c_f     = status[1];
    v_f     = status[0];
    if (mem_op) begin
      alu_res = sum[31:0];
      c_f     = sum[32];
      v_f     = (bus.Val_Rn_in[31] == add_b[31]) && (sum[31] != bus.Val_Rn_in[31]);
    end else begin
      unique case (bus.EXE_CMD_in)
        CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
          alu_res = sum[31:0];
          c_f     = sum[32];
          v_f     = (bus.Val_Rn_in[31] == add_b[31]) && (sum[31] != bus.Val_Rn_in[31]);
        end
        CMD_MOV: alu_res = val2;
        CMD_MVN: alu_res = ~val2;
        CMD_AND: alu_res = bus.Val_Rn_in & val2;
        CMD_ORR: alu_res = bus.Val_Rn_in | val2;
        CMD_EOR: alu_res = bus.Val_Rn_in ^ val2;
        CMD_MUL: alu_res = mul_res;
        default: alu_res = '0;
      endcase
    end
    n_f = alu_res[31];
    z_f = (alu_res == 32'b0);
  end

`ifdef EXE_MUL_EN
  localparam int MUL_ITERS = 32 / MUL_STEP;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

  mul_state_t  state, state_nxt;
  logic [31:0] mcand, mplier, acc;
  logic [5:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        MUL_IDLE: if (is_mul) begin
          mcand  <= bus.Val_Rn_in;
          mplier <= bus.Val_Rm_in;
          acc    <= '0;
          cnt    <= '0;
        end
        MUL_BUSY: begin
          acc    <= acc + mcand * {{(32-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    unique case (state)
      MUL_IDLE: if (is_mul) begin
        state_nxt = MUL_BUSY;
        stall_raw = 1'b1;
      end
      MUL_BUSY: begin
        stall_raw = 1'b1;
        if (cnt == 6'(MUL_ITERS - 1)) state_nxt = MUL_DONE;
      end
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  assign mul_res  = (state == MUL_DONE) ? acc : 32'b0;
  assign mul_kill = 1'b0;
`else
  assign stall_raw = 1'b0;
  assign mul_res   = '0;
  assign mul_kill  = is_mul;
`endif

  // A MUL is only unstalled on its DONE cycle, so S_in with no stall means the product is final.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= '0;
    end else if (bus.S_in && !stall) begin
      if (is_mul) begin
`ifdef EXE_MUL_EN
        status <= {n_f, z_f, status[1:0]};
`endif
      end else begin
        status <= {n_f, z_f, c_f, v_f};
      end
    end
  end

  assign bus.ALU_result   = alu_res;
  assign bus.Val_Rm_out   = bus.Val_Rm_in;
  assign bus.Dest_out     = bus.Dest_in;
  assign bus.WB_EN_out    = bus.WB_EN_in & ~stall & ~mul_kill;
  assign bus.MEM_R_EN_out = bus.MEM_R_EN_in & ~stall;
  assign bus.MEM_W_EN_out = bus.MEM_W_EN_in & ~stall;
  assign bus.branch_taken = bus.B_in & ~stall;
  assign bus.branch_addr  = bus.PC_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};
  assign bus.status_out   = status;
  assign bus.stall_out    = stall;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage; expectations follow the EXE_MUL_EN build setting.
module tb_exe_stage;

`ifdef EXE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int MUL_STALL = MUL_ON ? 17 : 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.WB_EN_in         = 1'b0;
    bus.MEM_R_EN_in      = 1'b0;
    bus.MEM_W_EN_in      = 1'b0;
    bus.B_in             = 1'b0;
    bus.S_in             = 1'b0;
    bus.EXE_CMD_in       = 4'b0000;
    bus.PC_in            = '0;
    bus.Val_Rn_in        = '0;
    bus.Val_Rm_in        = '0;
    bus.imm_in           = 1'b0;
    bus.shift_operand_in = '0;
    bus.signed_imm_24_in = '0;
    bus.Dest_in          = '0;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, input logic i,
                       input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
    clear_inputs();
    bus.EXE_CMD_in       = cmd;
    bus.S_in             = s;
    bus.imm_in           = i;
    bus.shift_operand_in = so;
    bus.Val_Rn_in        = rn;
    bus.Val_Rm_in        = rm;
    bus.WB_EN_in         = 1'b1;
    bus.Dest_in          = 4'd5;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts stall cycles from the issue cycle onward; the cycle where stall drops is DONE.
  task automatic run_mul(input string tag, input logic [31:0] exp_res);
    int  n_stall = 0;
    int  n_wb    = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!bus.stall_out) break;
      n_stall++;
      if (bus.WB_EN_out) n_wb++;
    end
    check({tag, "_stall_cycles"}, n_stall, MUL_STALL);
    check({tag, "_wb_during_stall"}, n_wb, 0);
    check({tag, "_result"}, bus.ALU_result, exp_res);
    check({tag, "_wb_done"}, {31'b0, bus.WB_EN_out}, {31'b0, MUL_ON});
  endtask

  initial begin
    clear_inputs();
    #3;
    check("rst_alu", bus.ALU_result, 32'h0);
    check("rst_status", {28'b0, bus.status_out}, 32'h0);
    check("rst_stall", {31'b0, bus.stall_out}, 32'h0);
    check("rst_baddr", bus.branch_addr, 32'h0);
    check("rst_wb", {31'b0, bus.WB_EN_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    next_cycle();
    drive(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0);
    #3;
    check("add_res", bus.ALU_result, 32'h8000_0000);
    check("add_wb", {31'b0, bus.WB_EN_out}, 32'h1);
    next_cycle();
    check("add_status", {28'b0, bus.status_out}, 32'h9);

    drive(4'b0100, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
    #3;
    check("sub_res", bus.ALU_result, 32'h0);
    next_cycle();
    check("sub_status", {28'b0, bus.status_out}, 32'h6);

    drive(4'b0101, 1'b1, 1'b1, 12'h003, 32'd5, 32'h0);
    #3;
    check("sbc_res", bus.ALU_result, 32'd2);
    next_cycle();
    check("sbc_status", {28'b0, bus.status_out}, 32'h2);

    drive(4'b0001, 1'b0, 1'b0, 12'h0C0, 32'h0, 32'h8000_0000);
    #3;
    check("mov_asr", bus.ALU_result, 32'hC000_0000);
    check("rm_pass", bus.Val_Rm_out, 32'h8000_0000);
    check("dest_pass", {28'b0, bus.Dest_out}, 32'h5);

    next_cycle();
    check("status_hold", {28'b0, bus.status_out}, 32'h2);
    drive(4'b0001, 1'b0, 1'b1, 12'h2FF, 32'h0, 32'h0);
    #3;
    check("mov_imm_rot", bus.ALU_result, 32'hF000_000F);

    next_cycle();
    drive(4'b1001, 1'b0, 1'b0, 12'h260, 32'h0, 32'h0000_00F1);
    #3;
    check("mvn_ror", bus.ALU_result, 32'hEFFF_FFF0);

    next_cycle();
    drive(4'b0110, 1'b0, 1'b1, 12'h0FF, 32'h0000_F0F0, 32'h0);
    #3;
    check("and", bus.ALU_result, 32'h0000_00F0);
    next_cycle();
    drive(4'b0111, 1'b0, 1'b1, 12'h00F, 32'h0000_0F00, 32'h0);
    #3;
    check("orr", bus.ALU_result, 32'h0000_0F0F);
    next_cycle();
    drive(4'b1000, 1'b0, 1'b1, 12'h00F, 32'h0000_00FF, 32'h0);
    #3;
    check("eor", bus.ALU_result, 32'h0000_00F0);

    next_cycle();
    clear_inputs();
    bus.B_in             = 1'b1;
    bus.PC_in            = 32'h100;
    bus.signed_imm_24_in = 24'hFFFFFE;
    #3;
    check("br_taken", {31'b0, bus.branch_taken}, 32'h1);
    check("br_addr", bus.branch_addr, 32'h0000_00F8);

    next_cycle();
    drive(4'b0010, 1'b0, 1'b0, 12'h008, 32'h40, 32'h0);
    bus.MEM_R_EN_in = 1'b1;
    #3;
    check("ldr_addr", bus.ALU_result, 32'h48);
    check("ldr_mem_r", {31'b0, bus.MEM_R_EN_out}, 32'h1);

    next_cycle();
    drive(4'b1010, 1'b1, 1'b0, 12'h000, 32'd7, 32'd6);
    bus.B_in = 1'b1;
    #3;
    check("mul_issue_br", {31'b0, bus.branch_taken}, {31'b0, ~MUL_ON});
    run_mul("mul7x6", MUL_ON ? 32'd42 : 32'd0);
    next_cycle();
    check("mul_status", {28'b0, bus.status_out}, 32'h2);

    drive(4'b1010, 1'b0, 1'b0, 12'h000, 32'd3, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    check("busy_stall", {31'b0, bus.stall_out}, {31'b0, MUL_ON});
    rst = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, bus.stall_out}, 32'h0);
    check("rst_mid_status", {28'b0, bus.status_out}, 32'h0);
    #1;
    rst = 1'b1;
    run_mul("mul3x3", MUL_ON ? 32'd9 : 32'd0);

    next_cycle();
    clear_inputs();
    #3;
    check("flush_alu", bus.ALU_result, 32'h0);
    check("flush_stall", {31'b0, bus.stall_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
